// File: rtl/gb_dma_pkg.sv
// Shared constants and types for the Game Boy OAM DMA engine.
// mirror_page() backs the optional OAM_DMA_ECHO_MIRROR_EN source remap.
package gb_dma_pkg;

  localparam int unsigned OAM_LEN      = 160;
  localparam logic [7:0]  OAM_LAST     = 8'h9F;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    DRAIN
  } dma_state_t;

  // Pages E0-FF alias echo RAM / IO; fold them back onto WRAM (C0-DF).
  function automatic logic [7:0] mirror_page(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: copies {page,00}..{page,9F} into OAM, one byte per M-cycle tick.
// Build option OAM_DMA_ECHO_MIRROR_EN remaps source pages E0-FF to page - 0x20.
module oam_dma_controller
  import gb_dma_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic        i_Reg_Write,
  input  logic [7:0]  i_Reg_Data,
  output logic [7:0]  o_Reg_Data,
  output logic [15:0] o_Src_Address,
  output logic        o_Src_Read,
  input  logic [7:0]  i_Src_Data,
  output logic [7:0]  o_OAM_Address,
  output logic [7:0]  o_OAM_Data,
  output logic        o_OAM_Write,
  output logic        o_Busy
);

  dma_state_t state;
  logic [7:0] idx;
  logic       pending;
  logic [7:0] pend_idx;
  logic [7:0] src_page;

`ifdef OAM_DMA_ECHO_MIRROR_EN
  assign src_page = mirror_page(o_Reg_Data);
`else
  assign src_page = o_Reg_Data;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      idx           <= 8'h00;
      pending       <= 1'b0;
      pend_idx      <= 8'h00;
      o_Reg_Data    <= 8'hFF;
      o_Src_Address <= 16'h0000;
      o_Src_Read    <= 1'b0;
      o_OAM_Address <= 8'h00;
      o_OAM_Data    <= 8'h00;
      o_OAM_Write   <= 1'b0;
      o_Busy        <= 1'b0;
    end else if (i_Enable) begin
      // A byte read last tick lands now in whatever busy state we are in.
      o_OAM_Write <= pending;
      if (pending) begin
        o_OAM_Address <= pend_idx;
        o_OAM_Data    <= i_Src_Data;
      end
      o_Src_Read <= 1'b0;
      pending    <= 1'b0;

      unique case (state)
        IDLE: ;
        START: state <= XFER;
        XFER: begin
          o_Src_Read    <= 1'b1;
          o_Src_Address <= {src_page, idx};
          pending       <= 1'b1;
          pend_idx      <= idx;
          if (idx == OAM_LAST) state <= DRAIN;
          else                 idx   <= idx + 8'd1;
        end
        DRAIN: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase

      // NOTE: the last non-blocking assignment wins, so a re-trigger overrides the
      // state/idx update above while the read and write issued this tick still go out.
      if (i_Reg_Write) begin
        o_Reg_Data <= i_Reg_Data;
        idx        <= 8'h00;
        state      <= START;
        o_Busy     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Game Boy OAM DMA engine, triggered by a CPU write to register FF46. Copies 160 bytes from `{page, 8'h00}` into OAM at one byte per M-cycle tick. It sits directly upstream of the memory map decoder: it drives the source address and access strobe into that decoder and takes back the returned byte. It also drives the OAM write port and exposes a busy flag that the CPU bus interface uses to lock out non-HRAM accesses.

## Interface
- No parameters.
- `i_Clk`  in  1  system clock
- `i_Rst`  in  1  synchronous reset, active-high
- `i_Enable`  in  1  M-cycle tick strobe; all state advances only on `i_Enable`
- `i_Reg_Write`  in  1  CPU write to FF46, sampled on tick
- `i_Reg_Data`  in  8  source page byte
- `o_Reg_Data`  out  8  FF46 readback (last page written)
- `o_Src_Address`  out  16  source address to memory map
- `o_Src_Read`  out  1  source access strobe (memory map `data_access`)
- `i_Src_Data`  in  8  byte for read issued on previous tick
- `o_OAM_Address`  out  8  OAM index 0x00–0x9F
- `o_OAM_Data`  out  8  OAM write data
- `o_OAM_Write`  out  1  OAM write strobe
- `o_Busy`  out  1  DMA in progress

## Operation
- States: IDLE, START, XFER, DRAIN. All outputs are registered and update only on ticks; each output is stable for the whole tick.
- **IDLE**
  - A tick with `i_Reg_Write` latches the page into `o_Reg_Data`, clears idx, and moves to START.
- **START**
  - No source read is issued.
  - If a byte is pending (re-trigger case), write it to OAM.
  - Then go to XFER.
- **XFER**
  - Read: `o_Src_Read`=1, `o_Src_Address`={page, idx}.
  - Write: if a byte is pending from the previous tick, `o_OAM_Write`=1 with `o_OAM_Address`=idx−1 and `o_OAM_Data`=`i_Src_Data`.
  - idx increments each tick. After idx 0x9F has been read, go to DRAIN.
- **DRAIN**
  - Write byte 0x9F; `o_Src_Read`=0.
  - Then go to IDLE.
- **Re-trigger** (`i_Reg_Write` in START/XFER/DRAIN):
  - Relatch the page and clear idx.
  - The current tick's read still completes, and its byte is written in the following START.
  - Go to START.
- idx is 8-bit and saturates at 0x9F; there is no wrap-around.
- `o_Busy`=1 in START, XFER and DRAIN.
- Reset values:
  - `o_Reg_Data`=0xFF
  - all strobes 0
  - `o_Src_Address`=0x0000
  - `o_OAM_Address`/`o_OAM_Data`=0x00
  - `o_Busy`=0
  - state IDLE, pending flag cleared
- Reset mid-transfer aborts immediately. OAM contents already written are kept.

## Timing
- Trigger on tick T gives START at T+1, reads at T+2..T+161, and writes at T+3..T+162.
- `o_Busy` is high from after tick T through tick T+162. Total length is 162 ticks.
- Source read latency is exactly one tick: `i_Src_Data` is valid on the tick after the one on which `o_Src_Read` was asserted.
- When `i_Enable` is low, all outputs hold and nothing advances.
- A simultaneous `i_Rst` and `i_Reg_Write`: reset wins.

## Configuration
- Macro: `OAM_DMA_ECHO_MIRROR_EN`.
- Defined: source pages 0xE0–0xFF are remapped to page − 0x20, so the engine reads WRAM rather than echo/IO space. Example: page 0xE1 reads 0xC100–0xC19F.
- Undefined: `o_Src_Address` is {page, idx} unmodified.
- `o_Reg_Data` always shows the unmodified page that was written.

## Structure
- Shared package `gb_dma_pkg`:
  - `OAM_LEN`=160
  - `OAM_LAST`=8'h9F
  - `DMA_REG_ADDR`=16'hFF46
  - `OAM_BASE`=16'hFE00
  - 2-bit state typedef `dma_state_t` {IDLE, START, XFER, DRAIN}
- Single module; no sub-module. The idx counter and FSM are too small to split.

## Test plan
- **Basic copy:** reset, write 0xC0 on tick T → reads 0xC000..0xC09F on T+2..T+161; OAM[i] = src byte i; `o_Busy` high for exactly 162 ticks.
- **Stall:** trigger page 0x80, hold `i_Enable` low for 5 cycles mid-transfer → outputs frozen; transfer resumes with no byte skipped or duplicated.
- **Re-trigger:** write 0xC1 at idx 0x40 → byte 0x40 is still written; the copy restarts at 0xC100 idx 0 two ticks later; the final OAM content is 0xC100..0xC19F.
- **Reset mid-transfer:** assert `i_Rst` at idx 0x20 → next cycle all strobes 0, `o_Busy`=0, `o_Reg_Data`=0xFF; OAM 0x00..0x1E unchanged afterwards.
- **Echo page 0xE0:**
  - with `OAM_DMA_ECHO_MIRROR_EN`: `o_Src_Address` 0xC000..0xC09F and `o_Reg_Data`=0xE0;
  - without it: 0xE000..0xE09F.
- **Boundary:** `o_OAM_Address` never exceeds 0x9F; `o_OAM_Write` is 0 in START after a fresh trigger from IDLE.
